// File: rtl/mips_exec_wb_core_pkg.sv
// Shared decode constants and control encodings for the MIPS subset execute/writeback core.
package mips_exec_wb_core_pkg;

  localparam logic [5:0] OP_RTYPE   = 6'h00;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0A;
  localparam logic [5:0] OP_SLTIU   = 6'h0B;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_GPIO_RD = 6'h3E;
  localparam logic [5:0] OP_GPIO_WR = 6'h3F;

  localparam logic [5:0] F_SLL   = 6'h00;
  localparam logic [5:0] F_SRL   = 6'h02;
  localparam logic [5:0] F_SRA   = 6'h03;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_ADDU  = 6'h21;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_SUBU  = 6'h23;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_XOR   = 6'h26;
  localparam logic [5:0] F_NOR   = 6'h27;
  localparam logic [5:0] F_SLT   = 6'h2A;
  localparam logic [5:0] F_SLTU  = 6'h2B;

  typedef enum logic [3:0] {
    ALU_AND, ALU_OR, ALU_XOR, ALU_NOR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLTU,
    ALU_SLL, ALU_SRL, ALU_SRA, ALU_MULT, ALU_MULTU, ALU_PASSB
  } alu_op_e;

  typedef enum logic [1:0] {RES_ALU, RES_HI, RES_LO, RES_GPIO} res_sel_e;

  typedef enum logic [1:0] {OPB_REG, OPB_SEXT, OPB_ZEXT} opb_sel_e;

endpackage

// File: rtl/mips_exec_wb_core_alu.sv
// Combinational ALU: logic, add/sub, compares, shifts of b by shamt, and 64-bit multiplies onto hi/lo.
module alu_core
  import mips_exec_wb_core_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [4:0]      shamt,
  input  logic [3:0]      op,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic            zero
);

  logic signed [XLEN-1:0]   a_s, b_s;
  logic signed [2*XLEN-1:0] a_x, b_x, prod_s;
  logic        [2*XLEN-1:0] prod_u;

  assign a_s    = a;
  assign b_s    = b;
  assign a_x    = {{XLEN{a[XLEN-1]}}, a};
  assign b_x    = {{XLEN{b[XLEN-1]}}, b};
  assign prod_s = a_x * b_x;
  assign prod_u = {{XLEN{1'b0}}, a} * {{XLEN{1'b0}}, b};

  always_comb begin
    hi = '0;
    lo = '0;
    case (alu_op_e'(op))
      ALU_AND:   lo = a & b;
      ALU_OR:    lo = a | b;
      ALU_XOR:   lo = a ^ b;
      ALU_NOR:   lo = ~(a | b);
      ALU_ADD:   lo = a + b;
      ALU_SUB:   lo = a - b;
      ALU_SLT:   lo = {{(XLEN-1){1'b0}}, (a_s < b_s)};
      ALU_SLTU:  lo = {{(XLEN-1){1'b0}}, (a < b)};
      ALU_SLL:   lo = b << shamt;
      ALU_SRL:   lo = b >> shamt;
      ALU_SRA:   lo = b_s >>> shamt;
      ALU_MULT:  {hi, lo} = prod_s;
      ALU_MULTU: {hi, lo} = prod_u;
      default:   lo = b;
    endcase
  end

  assign zero = (lo == '0);

endmodule

// File: rtl/mips_exec_wb_core_ctrl.sv
// Instruction decode: maps opcode/funct to ALU op, operand/result selects and write enables.
module ctrl_decode
  import mips_exec_wb_core_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic [4:0] rt,
  input  logic [4:0] rd,
  input  logic [4:0] shamt_in,
  output logic [3:0] alu_op,
  output logic [1:0] opb_sel,
  output logic [1:0] res_sel,
  output logic [4:0] shamt,
  output logic [4:0] dest,
  output logic       rf_we,
  output logic       hilo_we,
  output logic       gpio_we
);

  always_comb begin
    alu_op  = ALU_PASSB;
    opb_sel = OPB_REG;
    res_sel = RES_ALU;
    shamt   = shamt_in;
    dest    = rd;
    rf_we   = 1'b0;
    hilo_we = 1'b0;
    gpio_we = 1'b0;
    case (op)
      OP_RTYPE: begin
        case (funct)
          F_ADD, F_ADDU: begin alu_op = ALU_ADD;  rf_we = 1'b1; end
          F_SUB, F_SUBU: begin alu_op = ALU_SUB;  rf_we = 1'b1; end
          F_AND:         begin alu_op = ALU_AND;  rf_we = 1'b1; end
          F_OR:          begin alu_op = ALU_OR;   rf_we = 1'b1; end
          F_XOR:         begin alu_op = ALU_XOR;  rf_we = 1'b1; end
          F_NOR:         begin alu_op = ALU_NOR;  rf_we = 1'b1; end
          F_SLT:         begin alu_op = ALU_SLT;  rf_we = 1'b1; end
          F_SLTU:        begin alu_op = ALU_SLTU; rf_we = 1'b1; end
          F_SLL:         begin alu_op = ALU_SLL;  rf_we = 1'b1; end
          F_SRL:         begin alu_op = ALU_SRL;  rf_we = 1'b1; end
          F_SRA:         begin alu_op = ALU_SRA;  rf_we = 1'b1; end
          F_MULT:        begin alu_op = ALU_MULT;  hilo_we = 1'b1; end
          F_MULTU:       begin alu_op = ALU_MULTU; hilo_we = 1'b1; end
          F_MFHI:        begin res_sel = RES_HI; rf_we = 1'b1; end
          F_MFLO:        begin res_sel = RES_LO; rf_we = 1'b1; end
          default: ;
        endcase
      end
      OP_ADDI, OP_ADDIU: begin alu_op = ALU_ADD;  opb_sel = OPB_SEXT; dest = rt; rf_we = 1'b1; end
      OP_SLTI:           begin alu_op = ALU_SLT;  opb_sel = OPB_SEXT; dest = rt; rf_we = 1'b1; end
      OP_SLTIU:          begin alu_op = ALU_SLTU; opb_sel = OPB_SEXT; dest = rt; rf_we = 1'b1; end
      OP_ANDI:           begin alu_op = ALU_AND;  opb_sel = OPB_ZEXT; dest = rt; rf_we = 1'b1; end
      OP_ORI:            begin alu_op = ALU_OR;   opb_sel = OPB_ZEXT; dest = rt; rf_we = 1'b1; end
      OP_XORI:           begin alu_op = ALU_XOR;  opb_sel = OPB_ZEXT; dest = rt; rf_we = 1'b1; end
      // lui reuses the shifter: zero-extended immediate shifted left by 16.
      OP_LUI: begin
        alu_op = ALU_SLL; opb_sel = OPB_ZEXT; shamt = 5'd16; dest = rt; rf_we = 1'b1;
      end
      OP_GPIO_RD: begin res_sel = RES_GPIO; dest = rt; rf_we = 1'b1; end
      OP_GPIO_WR: gpio_we = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_exec_wb_core_rf.sv
// Register file: two async read ports with write-through from the WB stage, one sync write port.
module reg_file_32x32 #(
  parameter int NREGS = 32,
  parameter int XLEN  = 32,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   ra1,
  input  logic [AW-1:0]   ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  input  logic            we,
  input  logic [AW-1:0]   wa,
  input  logic [XLEN-1:0] wd
);

  logic [XLEN-1:0] mem [NREGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    end else if (we && (wa != '0)) begin
      mem[wa] <= wd;
    end
  end

  // The pending WB write wins so a dependent instruction right behind it needs no stall.
  always_comb begin
    rd1 = mem[ra1];
    rd2 = mem[ra2];
    if (we && (wa != '0) && (wa == ra1)) rd1 = wd;
    if (we && (wa != '0) && (wa == ra2)) rd2 = wd;
    if (ra1 == '0) rd1 = '0;
    if (ra2 == '0) rd2 = '0;
  end

endmodule

// File: rtl/mips_exec_wb_core.sv
// Decode/execute/writeback datapath: EX-stage decode, ALU, hi/lo, GPIO and the EX->WB register.
module mips_exec_wb_core
  import mips_exec_wb_core_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] gpio_in,
  output logic [XLEN-1:0] gpio_out,
  output logic            wb_we,
  output logic [4:0]      wb_addr,
  output logic [XLEN-1:0] wb_data
);

  logic [3:0]      alu_op_p0;
  logic [1:0]      opb_sel_p0, res_sel_p0;
  logic [4:0]      shamt_p0, dest_p0;
  logic            rf_we_p0, hilo_we_p0, gpio_we_p0;
  logic [XLEN-1:0] rs_val_p0, rt_val_p0, opb_p0, res_p0;
  logic [XLEN-1:0] alu_hi_p0, alu_lo_p0;
  logic            unused_alu_zero;
  logic [15:0]     imm_p0;
  logic [XLEN-1:0] hi_q, lo_q;
  logic            wb_we_p1;
  logic [4:0]      wb_addr_p1;
  logic [XLEN-1:0] wb_data_p1;

  assign imm_p0 = instr[15:0];

  // EX stage: decode, operand read, execute.
  ctrl_decode u_ctrl (
    .op      (instr[31:26]),
    .funct   (instr[5:0]),
    .rt      (instr[20:16]),
    .rd      (instr[15:11]),
    .shamt_in(instr[10:6]),
    .alu_op  (alu_op_p0),
    .opb_sel (opb_sel_p0),
    .res_sel (res_sel_p0),
    .shamt   (shamt_p0),
    .dest    (dest_p0),
    .rf_we   (rf_we_p0),
    .hilo_we (hilo_we_p0),
    .gpio_we (gpio_we_p0)
  );

  reg_file_32x32 #(.NREGS(NREGS), .XLEN(XLEN)) u_rf (
    .clk(clk),
    .rst(rst),
    .ra1(instr[25:21]),
    .ra2(instr[20:16]),
    .rd1(rs_val_p0),
    .rd2(rt_val_p0),
    .we (wb_we_p1),
    .wa (wb_addr_p1),
    .wd (wb_data_p1)
  );

  always_comb begin
    opb_p0 = rt_val_p0;
    case (opb_sel_p0)
      OPB_SEXT: opb_p0 = {{(XLEN-16){imm_p0[15]}}, imm_p0};
      OPB_ZEXT: opb_p0 = {{(XLEN-16){1'b0}}, imm_p0};
      default: ;
    endcase
  end

  alu_core #(.XLEN(XLEN)) u_alu (
    .a    (rs_val_p0),
    .b    (opb_p0),
    .shamt(shamt_p0),
    .op   (alu_op_p0),
    .hi   (alu_hi_p0),
    .lo   (alu_lo_p0),
    .zero (unused_alu_zero)
  );

  always_comb begin
    res_p0 = alu_lo_p0;
    case (res_sel_p0)
      RES_HI:   res_p0 = hi_q;
      RES_LO:   res_p0 = lo_q;
      RES_GPIO: res_p0 = gpio_in;
      default: ;
    endcase
  end

  // EX -> WB boundary: result, hi/lo and GPIO all commit on the edge ending EX.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_we_p1   <= 1'b0;
      wb_addr_p1 <= '0;
      wb_data_p1 <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      gpio_out   <= '0;
    end else begin
      wb_we_p1   <= rf_we_p0 && (dest_p0 != 5'd0);
      wb_addr_p1 <= dest_p0;
      wb_data_p1 <= res_p0;
      if (hilo_we_p0) begin
        hi_q <= alu_hi_p0;
        lo_q <= alu_lo_p0;
      end
      if (gpio_we_p0) gpio_out <= rt_val_p0;
    end
  end

  assign wb_we   = wb_we_p1;
  assign wb_addr = wb_addr_p1;
  assign wb_data = wb_data_p1;

endmodule

// File: tb/tb_mips_exec_wb_core.sv
// Directed bench for mips_exec_wb_core: hand-computed results observed on the WB port and gpio_out.
module tb_mips_exec_wb_core;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic [31:0] gpio_in;
  logic [31:0] gpio_out;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mips_exec_wb_core dut (
    .clk     (clk),
    .rst     (rst),
    .instr   (instr),
    .gpio_in (gpio_in),
    .gpio_out(gpio_out),
    .wb_we   (wb_we),
    .wb_addr (wb_addr),
    .wb_data (wb_data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  function automatic logic [31:0] r_op(input int rs, input int rt, input int rd, input int sh, input int fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
  endfunction

  function automatic logic [31:0] i_op(input int op, input int rs, input int rt, input int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  // Present one instruction for a full cycle; returns at the negedge after its WB capture.
  task automatic issue(input logic [31:0] ins);
    instr = ins;
    @(negedge clk);
  endtask

  // Read a register by copying it into scratch register $7 and observing wb_data.
  task automatic peek(input int r, input logic [31:0] exp, input string tag);
    issue(r_op(r, 0, 7, 0, 'h25));
    check(tag, wb_data, exp);
  endtask

  initial begin
    rst     = 1'b1;
    instr   = 32'h0;
    gpio_in = 32'h0;
    repeat (2) @(negedge clk);
    check("rst_wb_we", 32'(wb_we), 32'h0);
    check("rst_wb_addr", 32'(wb_addr), 32'h0);
    check("rst_wb_data", wb_data, 32'h0);
    check("rst_gpio_out", gpio_out, 32'h0);
    rst = 1'b0;

    issue(32'h2001FFFB);
    check("addi_we", 32'(wb_we), 32'h1);
    check("addi_addr", 32'(wb_addr), 32'h1);
    check("addi_data", wb_data, 32'hFFFFFFFB);
    issue(i_op('h0D, 0, 2, 'hFFFF));
    check("ori_addr", 32'(wb_addr), 32'h2);
    check("ori_data", wb_data, 32'h0000FFFF);
    issue(i_op('h0F, 0, 5, 'h1234));
    check("lui_data", wb_data, 32'h12340000);
    peek(1, 32'hFFFFFFFB, "rf_r1_addi");

    issue(i_op('h08, 0, 1, 7));
    issue(r_op(1, 1, 2, 0, 'h20));
    check("bypass_add_addr", 32'(wb_addr), 32'h2);
    check("bypass_add_data", wb_data, 32'd14);
    peek(2, 32'd14, "rf_r2_add");
    peek(1, 32'd7, "rf_r1_7");
    issue(i_op('h08, 0, 0, 5));
    issue(r_op(0, 0, 7, 0, 'h21));
    check("r0_stays_zero", wb_data, 32'h0);

    issue(i_op('h08, 0, 1, -2));
    issue(i_op('h08, 0, 2, 3));
    issue(r_op(1, 2, 0, 0, 'h18));
    check("mult_no_rf_write", 32'(wb_we), 32'h0);
    issue(r_op(0, 0, 3, 0, 'h10));
    check("mult_hi", wb_data, 32'hFFFFFFFF);
    issue(r_op(0, 0, 4, 0, 'h12));
    check("mult_lo", wb_data, 32'hFFFFFFFA);
    issue(r_op(1, 2, 0, 0, 'h19));
    issue(r_op(0, 0, 3, 0, 'h10));
    check("multu_hi", wb_data, 32'h00000002);
    issue(r_op(0, 0, 4, 0, 'h12));
    check("multu_lo", wb_data, 32'hFFFFFFFA);

    issue(i_op('h0F, 0, 1, 'h8000));
    issue(r_op(0, 1, 3, 4, 'h03));
    check("sra4", wb_data, 32'hF8000000);
    issue(r_op(2, 1, 3, 4, 'h02));
    check("srl4", wb_data, 32'h08000000);
    issue(r_op(0, 1, 3, 1, 'h00));
    check("sll1", wb_data, 32'h0);

    issue(i_op('h08, 0, 1, -1));
    issue(i_op('h08, 0, 2, 1));
    issue(r_op(1, 2, 3, 0, 'h2A));
    check("slt", wb_data, 32'h1);
    issue(r_op(1, 2, 3, 0, 'h2B));
    check("sltu", wb_data, 32'h0);
    issue(i_op('h0A, 1, 3, 1));
    check("slti", wb_data, 32'h1);
    issue(i_op('h0B, 1, 3, 1));
    check("sltiu", wb_data, 32'h0);
    issue(r_op(2, 1, 3, 0, 'h22));
    check("sub", wb_data, 32'h2);
    issue(r_op(0, 0, 3, 0, 'h27));
    check("nor", wb_data, 32'hFFFFFFFF);
    issue(i_op('h0C, 1, 3, 'hF0F0));
    check("andi_zext", wb_data, 32'h0000F0F0);
    issue(i_op('h0E, 1, 3, 'hFFFF));
    check("xori_zext", wb_data, 32'hFFFF0000);

    gpio_in = 32'hDEADBEEF;
    check("gpio_out_idle", gpio_out, 32'h0);
    issue(i_op('h3E, 0, 6, 0));
    check("gpio_rd_addr", 32'(wb_addr), 32'h6);
    check("gpio_rd_data", wb_data, 32'hDEADBEEF);
    issue(i_op('h3F, 0, 6, 0));
    check("gpio_wr", gpio_out, 32'hDEADBEEF);
    gpio_in = 32'h12345678;
    issue(i_op('h3E, 0, 0, 0));
    issue(r_op(0, 0, 7, 0, 'h21));
    check("gpio_rd_r0", wb_data, 32'h0);

    issue(i_op('h3D, 1, 6, 'hFFFF));
    check("nop_op_we", 32'(wb_we), 32'h0);
    check("nop_op_gpio", gpio_out, 32'hDEADBEEF);
    issue(r_op(1, 2, 6, 0, 'h3F));
    check("nop_funct_we", 32'(wb_we), 32'h0);
    peek(6, 32'hDEADBEEF, "nop_r6_kept");
    issue(r_op(0, 0, 3, 0, 'h10));
    check("nop_hi_kept", wb_data, 32'h00000002);

    issue(i_op('h08, 0, 1, 9));
    rst = 1'b1;
    #1;
    check("midrst_wb_we", 32'(wb_we), 32'h0);
    check("midrst_gpio", gpio_out, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    peek(1, 32'h0, "midrst_r1");
    peek(6, 32'h0, "midrst_r6");
    issue(r_op(0, 0, 3, 0, 'h10));
    check("midrst_hi", wb_data, 32'h0);
    issue(r_op(0, 0, 4, 0, 'h12));
    check("midrst_lo", wb_data, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
